// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(2^WIDTH) multiplier slice.
package gf_pkg;

  // Multiplier control states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } gf_state_t;

  // AES field polynomial x^8+x^4+x^3+x+1 with the implicit x^8 term dropped.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Ceiling log2, used to size the step counter.
  function automatic int unsigned gf_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Combinational field doubling: multiply v by x modulo (x^WIDTH + POLY).
module gf_xtime #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = 8'h1B
) (
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] y
);

  // Shift left and fold the dropped MSB back in through the polynomial.
  always_comb begin
    y = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  end

endmodule

// File: rtl/gf_mult_seq.sv
// Iterative GF(2^WIDTH) shift-and-add multiplier, one multiplier bit per cycle,
// with valid/ready handshakes on both sides.
module gf_mult_seq
  import gf_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(AES_POLY),
  parameter bit               EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             busy
);

  localparam int unsigned CntW = gf_clog2(WIDTH);

  gf_state_t        state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_dbl;
  logic             cnt_last;
  logic             accept;

  gf_xtime #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_xtime (
    .v (a_q),
    .y (a_dbl)
  );

  // Handshake and status decode; in_ready also opens in DONE when the product drains.
  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_p     = acc_q;
    accept    = in_valid && in_ready;
    cnt_last  = (cnt_q == CntW'(WIDTH - 1));
  end

  // FSM plus datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StRun;
          end else if (state_q == StDone && out_ready) begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (EARLY_EXIT && (b_q == '0)) begin
            state_q <= StDone;
          end else begin
            acc_q <= acc_q ^ (b_q[0] ? a_q : '0);
            a_q   <= a_dbl;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_last) begin
              state_q <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
